// File: rtl/run_sequencer_if.sv
// Host, core and arbitrated-memory signal bundle for run_sequencer.
// The slave modport is the sequencer side; the master modport is the host/core side.
interface run_sequencer_if #(
    parameter int W  = 8,
    parameter int CW = 16
);
    logic          req;
    logic          done;
    logic          timeout;
    logic          busy;
    logic          core_rst;
    logic          core_done;
    logic          host_we;
    logic [W-1:0]  host_addr;
    logic [W-1:0]  host_din;
    logic          host_ack;
    logic          core_we;
    logic [W-1:0]  core_addr;
    logic [W-1:0]  core_din;
    logic          mem_we;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_din;
    logic [CW-1:0] cyc_cnt;

    modport master (
        output req, core_done, host_we, host_addr, host_din, core_we, core_addr, core_din,
        input  done, timeout, busy, core_rst, host_ack, mem_we, mem_addr, mem_din, cyc_cnt
    );

    modport slave (
        input  req, core_done, host_we, host_addr, host_din, core_we, core_addr, core_din,
        output done, timeout, busy, core_rst, host_ack, mem_we, mem_addr, mem_din, cyc_cnt
    );
endinterface

// File: rtl/run_sequencer.sv
// Run sequencer: holds the core in reset, arbitrates its data memory with a host preload port, runs it to completion or cycle limit.
// START follows req by one edge; done is registered; there is no backpressure, and host writes outside IDLE are dropped (host_ack=0).
module run_sequencer #(
    parameter int W       = 8,
    parameter int MAX_CYC = 4096,
    parameter int CW      = 16
) (
    input logic            clk,
    input logic            reset,
    run_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          timeout_q;
    logic          done_q;
    logic          limit_hit;
    logic          host_sel;
    logic          run_phase;
    logic [W-1:0]  sel_addr;
    logic [W-1:0]  sel_din;

    assign limit_hit = (cnt == CW'(MAX_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.req) nxt = START;
            START:   nxt = RUN;
            RUN:     if (bus.core_done || limit_hit) nxt = DONE;
            DONE:    if (!bus.req) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Reset gates the write strobes directly so an abort cannot leak a write.
    always_comb begin
        host_sel     = (state == IDLE);
        run_phase    = (state == RUN);
        sel_addr     = host_sel ? bus.host_addr : bus.core_addr;
        sel_din      = host_sel ? bus.host_din  : bus.core_din;
        bus.busy     = (state == START) || run_phase;
        bus.core_rst = !run_phase;
        bus.host_ack = reset && host_sel && bus.host_we;
        bus.mem_we   = reset && (host_sel ? bus.host_we : (run_phase && bus.core_we));
        bus.mem_addr = sel_addr;
        bus.mem_din  = sel_din;
    end

    // The counter does not advance on the exit cycle, so it reports RUN cycles elapsed before the stop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (nxt == DONE);
            if (state == IDLE && nxt == START) begin
                cnt       <= '0;
                timeout_q <= 1'b0;
            end else if (state == RUN) begin
                if (nxt == DONE)
                    timeout_q <= !bus.core_done;
                else if (cnt != {CW{1'b1}})
                    cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.cyc_cnt = cnt;
endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: memory-mux vector table, hand-written corner sequences and randomized runs against an outcome model.
module tb_run_sequencer;
    localparam int W    = 8;
    localparam int CW   = 16;
    localparam int MAXC = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    run_sequencer_if #(.W(W), .CW(CW)) bus ();

    run_sequencer #(.W(W), .MAX_CYC(MAXC), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       run;
        logic       hwe;
        logic [7:0] ha;
        logic [7:0] hd;
        logic       cwe;
        logic [7:0] ca;
        logic [7:0] cd;
        logic       exp_we;
        logic [7:0] exp_a;
        logic [7:0] exp_d;
        logic       exp_ack;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Outcome model: a run stops after k+1 RUN cycles if core_done arrives at elapsed count k within the limit, else after MAXC cycles.
    task automatic run_once(input int k, input int drop_at, input string tag);
        int         n;
        int         exp_len;
        int         exp_cnt;
        logic       hit;
        logic       exp_to;
        logic       cwe;
        logic [7:0] ca;
        logic [7:0] cd;
        hit     = (k >= 0) && (k <= MAXC - 1);
        exp_len = hit ? k + 1 : MAXC;
        exp_cnt = exp_len - 1;
        exp_to  = !hit;
        bus.req       = 1'b1;
        bus.core_done = 1'b0;
        bus.core_we   = 1'b1;
        tick();
        chk({tag, "_start_busy"},     bus.busy, 1);
        chk({tag, "_start_core_rst"}, bus.core_rst, 1);
        chk({tag, "_start_cnt"},      bus.cyc_cnt, 0);
        chk({tag, "_start_timeout"},  bus.timeout, 0);
        chk({tag, "_start_mem_we"},   bus.mem_we, 0);
        chk({tag, "_start_host_ack"}, bus.host_ack, 0);
        tick();
        n = 0;
        while (!bus.done && n < 40) begin
            cwe = 1'($urandom);
            ca  = 8'($urandom);
            cd  = 8'($urandom);
            bus.core_we   = cwe;
            bus.core_addr = ca;
            bus.core_din  = cd;
            bus.host_we   = 1'($urandom);
            bus.host_addr = 8'($urandom);
            bus.host_din  = 8'($urandom);
            bus.core_done = (n == k);
            if (n == drop_at) bus.req = 1'b0;
            #1;
            chk({tag, "_run_core_rst"}, bus.core_rst, 0);
            chk({tag, "_run_mem_we"},   bus.mem_we, cwe);
            chk({tag, "_run_mem_addr"}, bus.mem_addr, ca);
            chk({tag, "_run_mem_din"},  bus.mem_din, cd);
            chk({tag, "_run_host_ack"}, bus.host_ack, 0);
            chk({tag, "_run_cnt"},      bus.cyc_cnt, n);
            tick();
            n++;
        end
        bus.core_done = 1'b0;
        bus.core_we   = 1'b1;
        bus.host_we   = 1'b0;
        chk({tag, "_run_length"},    n, exp_len);
        chk({tag, "_done"},          bus.done, 1);
        chk({tag, "_timeout"},       bus.timeout, exp_to);
        chk({tag, "_cnt"},           bus.cyc_cnt, exp_cnt);
        chk({tag, "_done_core_rst"}, bus.core_rst, 1);
        chk({tag, "_done_busy"},     bus.busy, 0);
        #1;
        chk({tag, "_done_mem_we"},   bus.mem_we, 0);
        bus.req = 1'b1;
        tick();
        chk({tag, "_done_held"},     bus.done, 1);
        chk({tag, "_done_cnt_held"}, bus.cyc_cnt, exp_cnt);
        bus.req = 1'b0;
        tick();
        chk({tag, "_idle_done"},     bus.done, 0);
        chk({tag, "_idle_cnt"},      bus.cyc_cnt, exp_cnt);
        chk({tag, "_idle_timeout"},  bus.timeout, exp_to);
        chk({tag, "_idle_core_rst"}, bus.core_rst, 1);
        chk({tag, "_idle_busy"},     bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       in_run;
        logic       hwe;
        logic [7:0] ha;
        logic [7:0] hd;

        tbl[0] = '{1'b0, 1'b1, 8'h05, 8'hA3, 1'b0, 8'h11, 8'h22, 1'b1, 8'h05, 8'hA3, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 8'h3C, 8'hFF, 1'b1, 8'h44, 8'h55, 1'b0, 8'h3C, 8'hFF, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h77, 8'h88, 1'b1, 8'hFF, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h99, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'h05, 8'hA3, 1'b1, 8'h66, 8'h77, 1'b1, 8'h66, 8'h77, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 8'h12, 8'h34, 1'b1, 8'h80, 8'h01, 1'b1, 8'h80, 8'h01, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'hAB, 8'hCD, 1'b0, 8'hC0, 8'hDE, 1'b0, 8'hC0, 8'hDE, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFE, 8'hED, 1'b0, 8'hFE, 8'hED, 1'b0};

        reset         = 1'b0;
        bus.req       = 1'b0;
        bus.core_done = 1'b0;
        bus.host_we   = 1'b1;
        bus.host_addr = 8'h10;
        bus.host_din  = 8'h20;
        bus.core_we   = 1'b1;
        bus.core_addr = 8'h30;
        bus.core_din  = 8'h40;
        #3;
        chk("rst_done",     bus.done, 0);
        chk("rst_timeout",  bus.timeout, 0);
        chk("rst_busy",     bus.busy, 0);
        chk("rst_core_rst", bus.core_rst, 1);
        chk("rst_cnt",      bus.cyc_cnt, 0);
        chk("rst_mem_we",   bus.mem_we, 0);
        chk("rst_host_ack", bus.host_ack, 0);
        tick();
        tick();
        reset = 1'b1;

        in_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].run && !in_run) begin
                bus.host_we = 1'b0;
                bus.req     = 1'b1;
                tick();
                tick();
                in_run = 1'b1;
            end
            bus.host_we   = tbl[i].hwe;
            bus.host_addr = tbl[i].ha;
            bus.host_din  = tbl[i].hd;
            bus.core_we   = tbl[i].cwe;
            bus.core_addr = tbl[i].ca;
            bus.core_din  = tbl[i].cd;
            #1;
            chk($sformatf("vec%0d_mem_we", i),   bus.mem_we, tbl[i].exp_we);
            chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, tbl[i].exp_a);
            chk($sformatf("vec%0d_mem_din", i),  bus.mem_din, tbl[i].exp_d);
            chk($sformatf("vec%0d_host_ack", i), bus.host_ack, tbl[i].exp_ack);
            tick();
        end
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        bus.core_we   = 1'b1;
        chk("vec_done",     bus.done, 1);
        chk("vec_timeout",  bus.timeout, 0);
        chk("vec_cnt",      bus.cyc_cnt, 4);
        chk("vec_core_rst", bus.core_rst, 1);
        #1;
        chk("vec_done_mem_we", bus.mem_we, 0);
        bus.req = 1'b0;
        tick();
        chk("vec_idle_done", bus.done, 0);
        chk("vec_idle_cnt",  bus.cyc_cnt, 4);

        bus.req       = 1'b1;
        bus.host_we   = 1'b1;
        bus.host_addr = 8'h5A;
        bus.host_din  = 8'h3C;
        #1;
        chk("req_write_ack",    bus.host_ack, 1);
        chk("req_write_mem_we", bus.mem_we, 1);
        chk("req_write_addr",   bus.mem_addr, 8'h5A);
        chk("req_write_din",    bus.mem_din, 8'h3C);
        run_once(10, 3, "normal");
        run_once(-1, -1, "timeout");
        run_once(15, -1, "tie");
        run_once(14, 7, "near_limit");
        run_once(0, 0, "first_cycle");

        bus.req       = 1'b1;
        bus.core_done = 1'b0;
        tick();
        tick();
        repeat (4) tick();
        bus.core_we = 1'b1;
        bus.host_we = 1'b1;
        #1;
        chk("abort_pre_mem_we", bus.mem_we, 1);
        chk("abort_pre_busy",   bus.busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_done",     bus.done, 0);
        chk("abort_timeout",  bus.timeout, 0);
        chk("abort_busy",     bus.busy, 0);
        chk("abort_core_rst", bus.core_rst, 1);
        chk("abort_cnt",      bus.cyc_cnt, 0);
        chk("abort_mem_we",   bus.mem_we, 0);
        chk("abort_host_ack", bus.host_ack, 0);
        tick();
        chk("abort_hold_busy",   bus.busy, 0);
        chk("abort_hold_mem_we", bus.mem_we, 0);
        bus.host_we = 1'b0;
        reset = 1'b1;
        #1;
        chk("release_idle_busy", bus.busy, 0);
        tick();
        chk("release_start_busy",     bus.busy, 1);
        chk("release_start_core_rst", bus.core_rst, 1);
        tick();
        chk("release_run_core_rst", bus.core_rst, 0);
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        chk("release_done",    bus.done, 1);
        chk("release_timeout", bus.timeout, 0);
        chk("release_cnt",     bus.cyc_cnt, 0);
        bus.req = 1'b0;
        tick();
        chk("release_idle_done", bus.done, 0);

        for (int r = 0; r < 12; r++) begin
            for (int p = 0; p < 3; p++) begin
                hwe = 1'($urandom);
                ha  = 8'($urandom);
                hd  = 8'($urandom);
                bus.host_we   = hwe;
                bus.host_addr = ha;
                bus.host_din  = hd;
                bus.core_we   = 1'($urandom);
                bus.core_addr = 8'($urandom);
                bus.core_din  = 8'($urandom);
                #1;
                chk("pre_mem_we",   bus.mem_we, hwe);
                chk("pre_mem_addr", bus.mem_addr, ha);
                chk("pre_mem_din",  bus.mem_din, hd);
                chk("pre_host_ack", bus.host_ack, hwe);
                tick();
            end
            run_once(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 The module SHALL take parameter W, default 8, as the data memory data and address width.
REQ-002 The module SHALL take parameter MAX_CYC, default 4096, as the run-cycle limit before forced stop.
REQ-003 The module SHALL take parameter CW, default 16, as the cycle counter width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req, input, 1 bit: host start request; level-sensitive.
REQ-007 Port done, output, 1 bit: run complete; held until req deasserts.
REQ-008 Port timeout, output, 1 bit: the last run ended by cycle limit, not core completion.
REQ-009 Port busy, output, 1 bit: high in START and RUN.
REQ-010 Port core_rst, output, 1 bit: active-high hold-reset to processor core.
REQ-011 Port core_done, input, 1 bit: core end-of-program indication.
REQ-012 Ports host_we (1), host_addr (W), host_din (W), inputs: host preload write port.
REQ-013 Port host_ack, output, 1 bit: host write accepted this cycle.
REQ-014 Ports core_we (1), core_addr (W), core_din (W), inputs: core data memory write port.
REQ-015 Ports mem_we (1), mem_addr (W), mem_din (W), outputs: arbitrated data memory write port.
REQ-016 Port cyc_cnt, output, CW bits: RUN cycles elapsed in current/last run.

Function
REQ-017 The module SHALL implement the states IDLE, START, RUN, DONE.
REQ-018 IDLE: core_rst=1; host owns memory; if req=1, next state SHALL be START.
REQ-019 START: one cycle only; core_rst=1; cyc_cnt cleared to 0; timeout cleared to 0; next state RUN.
REQ-020 RUN: core_rst=0; core owns memory; cyc_cnt increments by 1 each cycle, saturating at 2^CW-1.
REQ-021 RUN: core_done=1 SHALL move to DONE next cycle with timeout=0.
REQ-022 RUN: cyc_cnt=MAX_CYC-1 with core_done=0 SHALL move to DONE with timeout=1.
REQ-023 RUN: if core_done=1 and the limit are hit together, core_done SHALL win (timeout=0).
REQ-024 RUN: req deasserting SHALL NOT abort the run.
REQ-025 DONE: done=1, core_rst=1; cyc_cnt and timeout frozen; on req=0 next state IDLE.
REQ-026 done SHALL be a registered output: high exactly while in DONE.
REQ-027 Memory mux: in IDLE, mem_* = host_*; in START, RUN and DONE, mem_* = core_*, with mem_we forced to 0 outside RUN.
REQ-028 host_ack SHALL equal host_we while in IDLE and 0 otherwise; host writes outside IDLE are dropped.
REQ-029 In IDLE with req=1 and host_we=1 together, the host write SHALL be accepted that cycle, then START.
REQ-030 cyc_cnt SHALL retain its last value through DONE and IDLE until the next START.

Reset
REQ-031 While reset=0, the module SHALL force state=IDLE, done=0, timeout=0, busy=0, core_rst=1, cyc_cnt=0, asynchronously.
REQ-032 Reset asserted mid-RUN SHALL abort immediately; the core returns to hold, and no mem_we is issued after assertion.
REQ-033 After reset release with req already high, START SHALL follow on the first clock edge.

Verification
REQ-034 Preload: IDLE, host_we=1, addr 0x05, din 0xA3 -> mem_we=1, mem_addr=0x05, mem_din=0xA3, host_ack=1.
REQ-035 Normal run: req=1, core_done pulses 10 cycles into RUN -> done=1, timeout=0, cyc_cnt=10, core_rst=1; req=0 -> IDLE next cycle.
REQ-036 Timeout: MAX_CYC=16, core_done held 0 -> DONE after 16 RUN cycles, timeout=1, cyc_cnt=15.
REQ-037 Contention: host_we=1 during RUN while core_we=1 -> host_ack=0; mem_* carries core values only.
REQ-038 Abort: reset=0 in the 5th RUN cycle -> all outputs at reset values within the same cycle; mem_we=0.
REQ-039 Tie: core_done=1 on the cycle with cyc_cnt=MAX_CYC-1 -> DONE with timeout=0.
